reg_pipe: RTL and testbench

Parametrised elastic register pipeline: a chain of `DEPTH` skid-buffered register stages moving `WIDTH`-bit words under a valid/ready handshake. It is the next generation of the team's plain load/enable register: in place of a one-word `load`/`enable` pair, every stage is back-pressure aware and runs at full throughput. It sits on any internal datapath that needs registered timing cuts, such as bus bridges, sensor sample paths and ADC/UART data paths, without losing or duplicating words when the consumer stalls.

---
 rtl/reg_pipe_pkg.sv | 13 +
 rtl/reg_pipe_stage.sv | 80 ++++++++
 rtl/reg_pipe.sv | 58 +++++
 tb/tb_reg_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the reg_pipe elastic register pipeline.
// Holds the default geometry and the main/skid storage beat type.
package reg_pipe_pkg;

    localparam int REG_PIPE_WIDTH = 8;
    localparam int REG_PIPE_DEPTH = 2;

    typedef struct packed {
        logic                      valid;
        logic [REG_PIPE_WIDTH-1:0] data;
    } reg_pipe_beat_t;

endpackage

// File: rtl/reg_pipe_stage.sv
// One skid-buffered valid/ready register stage of reg_pipe.
// The flush input exists only when REG_PIPE_FLUSH_EN is defined.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int  WIDTH  = REG_PIPE_WIDTH,
    parameter type beat_t = reg_pipe_beat_t
) (
    input  logic             clk,
    input  logic             rst,
`ifdef REG_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    beat_t m_r;
    beat_t s_r;
    beat_t m_nxt_s;
    beat_t s_nxt_s;
    logic  ready_r;
    logic  dn_free_s;
    logic  in_xfer_s;

    // Next main/skid contents; data fields only change when a word moves.
    always_comb begin
        dn_free_s = dn_ready | ~m_r.valid;
        in_xfer_s = up_valid & ready_r;
        m_nxt_s   = m_r;
        s_nxt_s   = s_r;
        if (dn_free_s) begin
            if (s_r.valid) begin
                m_nxt_s       = s_r;
                s_nxt_s.valid = 1'b0;
            end else if (in_xfer_s) begin
                m_nxt_s.valid = 1'b1;
                m_nxt_s.data  = up_data;
            end else begin
                m_nxt_s.valid = 1'b0;
            end
        end else if (in_xfer_s) begin
            // ready_r guarantees the skid is empty here
            s_nxt_s.valid = 1'b1;
            s_nxt_s.data  = up_data;
        end else begin
            s_nxt_s = s_r;
        end
    end

    // Stage state; ready tracks the next skid occupancy so it stays a pure register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r     <= '0;
            s_r     <= '0;
            ready_r <= 1'b0;
        end
`ifdef REG_PIPE_FLUSH_EN
        else if (flush) begin
            m_r.valid <= 1'b0;
            s_r.valid <= 1'b0;
            ready_r   <= 1'b1;
        end
`endif
        else begin
            m_r     <= m_nxt_s;
            s_r     <= s_nxt_s;
            ready_r <= ~s_nxt_s.valid;
        end
    end

    assign up_ready = ready_r;
    assign dn_valid = m_r.valid;
    assign dn_data  = m_r.data;

endmodule

// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH skid-buffered stages, capacity 2*DEPTH words.
// Define REG_PIPE_FLUSH_EN to add the synchronous flush input.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = REG_PIPE_WIDTH,
    parameter int DEPTH = REG_PIPE_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
`ifdef REG_PIPE_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } beat_t;

    // Index k is the link feeding stage k; index DEPTH is the pipeline output.
    logic [DEPTH:0]   vld_s;
    logic [DEPTH:0]   rdy_s;
    logic [WIDTH-1:0] dat_s [DEPTH+1];

    assign vld_s[0]     = in_valid;
    assign dat_s[0]     = in_data;
    assign in_ready     = rdy_s[0];
    assign rdy_s[DEPTH] = out_ready;
    assign out_valid    = vld_s[DEPTH];
    assign out_data     = dat_s[DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        reg_pipe_stage #(
            .WIDTH  (WIDTH),
            .beat_t (beat_t)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
`ifdef REG_PIPE_FLUSH_EN
            .flush    (flush),
`endif
            .up_valid (vld_s[k]),
            .up_data  (dat_s[k]),
            .up_ready (rdy_s[k]),
            .dn_valid (vld_s[k+1]),
            .dn_data  (dat_s[k+1]),
            .dn_ready (rdy_s[k+1])
        );
    end

endmodule

// File: tb/tb_reg_pipe.sv
// Scoreboard bench for reg_pipe (WIDTH=8, DEPTH=3); a FIFO model holds expected words.
// Flush scenario is built only when REG_PIPE_FLUSH_EN is defined.
module tb_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    int               n_chk  = 0;
    int               n_pass = 0;
    int               cyc    = 0;
    int               n_out  = 0;
    logic [WIDTH-1:0] last_out;
    bit               chk_lat = 1'b0;
    logic [WIDTH-1:0] exp_q [$];
    int               acc_q [$];

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef REG_PIPE_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One cycle: drive at negedge, then decide whether the coming edge accepts the word.
    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        acc = v && (in_ready === 1'b1) && !rst && !flush;
        if (acc) begin
            exp_q.push_back(d);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic drain(input int budget);
        bit a;
        for (int k = 0; k < budget && exp_q.size() != 0; k++) drive(1'b0, 8'h00, 1'b1, a);
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops the model on every output transfer and checks stall stability.
    initial begin
        bit               hold;
        logic [WIDTH-1:0] hold_d;
        logic [WIDTH-1:0] e;
        int               a;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst || flush) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, hold_d);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_word", out_data, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        a = acc_q.pop_front();
                        check("out_data", out_data, e);
                        if (chk_lat) check("latency", cyc - a, DEPTH);
                    end
                    n_out++;
                    last_out = out_data;
                end
                hold   = out_valid && !out_ready;
                hold_d = out_data;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit  acc;
        int  idx, nacc, n0, first, blen;
        bit  bon;
        bit  pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rel_in_ready", in_ready, 1);
        repeat (DEPTH + 1) drive(1'b0, 8'h00, 1'b1, acc);
        check("rst_no_word", out_valid, 0);
        check("rst_no_out", n_out, 0);

        // full-rate streaming with latency checking
        chk_lat = 1'b1;
        n0 = n_out;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 8'(i), 1'b1, acc);
            check("stream_accept", acc, 1);
        end
        drain(20);
        chk_lat = 1'b0;
        check("stream_count", n_out - n0, 16);

        // fill under stall, then recovery
        n0 = n_out; idx = 1; nacc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(idx), 1'b0, acc);
            if (acc) begin idx++; nacc++; end
        end
        check("fill_count", nacc, 2 * DEPTH);
        check("fill_in_ready", in_ready, 0);
        check("fill_no_out", n_out - n0, 0);
        first = -1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            drive(1'b0, 8'h00, 1'b1, acc);
            if (first < 0 && in_ready === 1'b1) first = i;
        end
        check("recover_cycles", (first >= 0 && first <= DEPTH), 1);
        check("fill_drain_empty", exp_q.size(), 0);
        check("fill_drain_count", n_out - n0, 2 * DEPTH);

        // random back-pressure with bursty producer
        n0 = n_out; nacc = 0; blen = 0; bon = 1'b0;
        for (int i = 0; i < 3000 && nacc < 200; i++) begin
            if (blen == 0) begin
                bon  = 1'($urandom_range(0, 1));
                blen = $urandom_range(1, 8);
            end
            blen--;
            drive(bon, 8'($urandom), pat[i % 5], acc);
            if (acc) nacc++;
        end
        check("rand_accepted", nacc, 200);
        drain(60);
        check("rand_count", n_out - n0, 200);

        // reset mid-stream discards stored words
        nacc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hA0 + 8'(i), 1'b0, acc);
            if (acc) nacc++;
        end
        check("mid_store", nacc, 4);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        n0 = n_out; acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) drive(1'b1, 8'h55, 1'b1, acc);
        check("mid_push", acc, 1);
        drain(20);
        check("mid_count", n_out - n0, 1);
        check("mid_first", last_out, 8'h55);

`ifdef REG_PIPE_FLUSH_EN
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0, acc);
            if (acc) nacc++;
        end
        check("flush_store", nacc, 5);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        #1;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        n0 = n_out; acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) drive(1'b1, 8'h77, 1'b1, acc);
        check("flush_push", acc, 1);
        drain(20);
        check("flush_count", n_out - n0, 1);
        check("flush_word", last_out, 8'h77);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
